// File: rtl/traffic_light_controller.sv
// Two-road intersection light controller: timed Moore FSM cycling
// main green/yellow/all-red then side green/yellow/all-red.
module traffic_light_controller #(
  parameter int CNT_W         = 8,
  parameter int T_MAIN_GREEN  = 8,
  parameter int T_MAIN_YELLOW = 3,
  parameter int T_SIDE_GREEN  = 5,
  parameter int T_SIDE_YELLOW = 3,
  parameter int T_ALL_RED     = 1
) (
  input  logic clk,
  input  logic rst,
  output logic MR,
  output logic MY,
  output logic MG,
  output logic SR,
  output logic SY,
  output logic SG
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_1   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_2   = 3'd5
  } state_t;

  // Terminal count per phase; a zero duration is treated as one cycle.
  function automatic logic [CNT_W-1:0] lim(input int t);
    return (t <= 1) ? '0 : CNT_W'(t - 1);
  endfunction

  localparam logic [CNT_W-1:0] L_MG = lim(T_MAIN_GREEN);
  localparam logic [CNT_W-1:0] L_MY = lim(T_MAIN_YELLOW);
  localparam logic [CNT_W-1:0] L_SG = lim(T_SIDE_GREEN);
  localparam logic [CNT_W-1:0] L_SY = lim(T_SIDE_YELLOW);
  localparam logic [CNT_W-1:0] L_AR = lim(T_ALL_RED);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  state_t           w_next;
  logic [CNT_W-1:0] w_lim;
  logic             w_legal;
  logic             w_adv;

  always_comb begin
    w_next  = MAIN_GREEN;
    w_lim   = '0;
    w_legal = 1'b1;
    case (r_state)
      MAIN_GREEN:  begin w_next = MAIN_YELLOW; w_lim = L_MG; end
      MAIN_YELLOW: begin w_next = ALL_RED_1;   w_lim = L_MY; end
      ALL_RED_1:   begin w_next = SIDE_GREEN;  w_lim = L_AR; end
      SIDE_GREEN:  begin w_next = SIDE_YELLOW; w_lim = L_SG; end
      SIDE_YELLOW: begin w_next = ALL_RED_2;   w_lim = L_SY; end
      ALL_RED_2:   begin w_next = MAIN_GREEN;  w_lim = L_AR; end
      default:     begin w_next = MAIN_GREEN;  w_legal = 1'b0; end
    endcase
  end

  // Illegal encodings recover on the very next edge regardless of timer.
  assign w_adv = !w_legal || (r_timer == w_lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MAIN_GREEN;
      r_timer <= '0;
    end else if (w_adv) begin
      r_state <= w_next;
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + CNT_W'(1);
    end
  end

  always_comb begin
    MR = 1'b1;
    MY = 1'b0;
    MG = 1'b0;
    SR = 1'b1;
    SY = 1'b0;
    SG = 1'b0;
    case (r_state)
      MAIN_GREEN:  begin MR = 1'b0; MG = 1'b1; end
      MAIN_YELLOW: begin MR = 1'b0; MY = 1'b1; end
      SIDE_GREEN:  begin SR = 1'b0; SG = 1'b1; end
      SIDE_YELLOW: begin SR = 1'b0; SY = 1'b1; end
      default:     ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: default timing plus an
// instance with a 1-cycle main green and 2-cycle all-red phases.
module tb_traffic_light_controller;

  localparam logic [5:0] P_MG = 6'b001_100;
  localparam logic [5:0] P_MY = 6'b010_100;
  localparam logic [5:0] P_AR = 6'b100_100;
  localparam logic [5:0] P_SG = 6'b100_001;
  localparam logic [5:0] P_SY = 6'b100_010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_mr, a_my, a_mg, a_sr, a_sy, a_sg;
  logic b_mr, b_my, b_mg, b_sr, b_sy, b_sg;
  logic [5:0] la, lb;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign la = {a_mr, a_my, a_mg, a_sr, a_sy, a_sg};
  assign lb = {b_mr, b_my, b_mg, b_sr, b_sy, b_sg};

  traffic_light_controller u_a (
    .clk(clk), .rst(rst),
    .MR(a_mr), .MY(a_my), .MG(a_mg),
    .SR(a_sr), .SY(a_sy), .SG(a_sg)
  );

  traffic_light_controller #(
    .T_MAIN_GREEN(1), .T_ALL_RED(2)
  ) u_b (
    .clk(clk), .rst(rst),
    .MR(b_mr), .MY(b_my), .MG(b_mg),
    .SR(b_sr), .SY(b_sy), .SG(b_sg)
  );

  // Expected lamps k edges after reset release, from phase durations.
  function automatic logic [5:0] exp_lamps(
    input int k, input int g, input int y, input int r,
    input int sg, input int sy
  );
    int p;
    p = k % (g + y + r + sg + sy + r);
    if (p < g) return P_MG;
    p -= g;
    if (p < y) return P_MY;
    p -= y;
    if (p < r) return P_AR;
    p -= r;
    if (p < sg) return P_SG;
    p -= sg;
    if (p < sy) return P_SY;
    return P_AR;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (la !== P_MG) begin
        errors++;
        $display("FAIL reset_a cyc%0d: got %b want %b", i, la, P_MG);
      end
      checks++;
      if (lb !== P_MG) begin
        errors++;
        $display("FAIL reset_b cyc%0d: got %b want %b", i, lb, P_MG);
      end
    end
  endtask

  task automatic test_cycle();
    logic [5:0] e;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 105; k++) begin
      #1;
      e = exp_lamps(k, 8, 3, 1, 5, 3);
      checks++;
      if (la !== e) begin
        errors++;
        $display("FAIL cycle k=%0d: got %b want %b", k, la, e);
      end
      checks++;
      if (!$onehot({a_mr, a_my, a_mg}) || !$onehot({a_sr, a_sy, a_sg})) begin
        errors++;
        $display("FAIL onehot k=%0d: got %b want one lamp per road", k, la);
      end
      checks++;
      if (!a_mr && !a_sr) begin
        errors++;
        $display("FAIL conflict k=%0d: got %b want a red road", k, la);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (13) @(negedge clk);
    checks++;
    if (la !== P_SG) begin
      errors++;
      $display("FAIL pre_async: got %b want %b", la, P_SG);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (la !== P_MG) begin
      errors++;
      $display("FAIL async_a: got %b want %b", la, P_MG);
    end
    checks++;
    if (lb !== P_MG) begin
      errors++;
      $display("FAIL async_b: got %b want %b", lb, P_MG);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      e = (k < 8) ? P_MG : P_MY;
      checks++;
      if (la !== e) begin
        errors++;
        $display("FAIL after_async k=%0d: got %b want %b", k, la, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_override();
    logic [5:0] e;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 34; k++) begin
      #1;
      e = exp_lamps(k, 1, 3, 2, 5, 3);
      checks++;
      if (lb !== e) begin
        errors++;
        $display("FAIL override k=%0d: got %b want %b", k, lb, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    // Immediate second reset pulse must restart the default cycle cleanly.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (la !== P_MY) begin
      errors++;
      $display("FAIL b2b_my: got %b want %b", la, P_MY);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (la !== P_AR) begin
      errors++;
      $display("FAIL b2b_ar: got %b want %b", la, P_AR);
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_async_reset();
    test_override();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
